// File: rtl/operand_entry.sv
// Front-panel entry stage: debounces three push buttons and loads operand A, operand B and the
// opcode from the switches in order, then strobes valid for one cycle.
module operand_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] no,
   input  logic       push1,
   input  logic       push2,
   input  logic       push3,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [2:0] opcode,
   output logic       valid,
   output logic       invalid_op,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      StA  = 2'd0,
      StB  = 2'd1,
      StOp = 2'd2,
      StGo = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Bit 0/1/2 of each vector belongs to push1/push2/push3.
   logic [2:0]       sync1_q;
   logic [2:0]       sync2_q;
   logic [2:0]       deb_q;
   logic [2:0]       deb_dly_q;
   logic [2:0]       press_q;
   logic [CNT_W-1:0] cnt_q [3];

   state_e     state_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [2:0] opcode_q;
   logic       valid_q;
   logic       invalid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         press_q   <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= {push3, push2, push1};
         sync2_q   <= sync1_q;
         deb_dly_q <= deb_q;
         // Registered edge strobe: one cycle per accepted rising level.
         press_q   <= deb_q & ~deb_dly_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CntLast) begin
               deb_q[i] <= ~deb_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Only the highest-priority press in a cycle is acted on; the rest are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StA;
         a_q       <= '0;
         b_q       <= '0;
         opcode_q  <= '0;
         valid_q   <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         invalid_q <= 1'b0;
         unique case (state_q)
            StA: begin
               if (press_q[0]) begin
                  a_q     <= no;
                  state_q <= StB;
               end
            end
            StB: begin
               if (press_q[0]) begin
                  a_q <= no;
               end else if (press_q[1]) begin
                  b_q     <= no;
                  state_q <= StOp;
               end
            end
            StOp: begin
               if (press_q[0]) begin
                  a_q     <= no;
                  state_q <= StB;
               end else if (press_q[1]) begin
                  b_q <= no;
               end else if (press_q[2]) begin
                  if (no <= 4'd4) begin
                     opcode_q <= no[2:0];
                     valid_q  <= 1'b1;
                     state_q  <= StGo;
                  end else begin
                     invalid_q <= 1'b1;
                  end
               end
            end
            StGo: begin
               state_q <= StA;
            end
         endcase
      end
   end

   assign a          = a_q;
   assign b          = b_q;
   assign opcode     = opcode_q;
   assign valid      = valid_q;
   assign invalid_op = invalid_q;
   assign state      = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed vector table, hand sequences and random stimulus
// checked every cycle against a raw-sample run-length reference model.
module tb_operand_entry;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] no;
   logic       push1, push2, push3;
   logic [3:0] a, b;
   logic [2:0] opcode;
   logic       valid, invalid_op;
   logic [1:0] state;

   always #5 clk = ~clk;

   operand_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .no        (no),
      .push1     (push1),
      .push2     (push2),
      .push3     (push3),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .valid     (valid),
      .invalid_op(invalid_op),
      .state     (state)
   );

   int total = 0;
   int bad   = 0;
   int vcnt, icnt;

   // Reference model: level accepted after D consecutive differing raw samples;
   // the resulting press acts on the FSM 4 edges after that last sample.
   int         m_a, m_b, m_op, m_state, m_valid, m_inv;
   int         lvl [3];
   int         run [3];
   logic [2:0] due [4];

   typedef struct {
      logic [3:0] no;
      logic [2:0] pins;
      int         hold;
      int         ea, eb, eop, est, env, eni;
   } vec_t;
   vec_t tbl [11];

   function automatic void check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_a = 0; m_b = 0; m_op = 0; m_state = 0; m_valid = 0; m_inv = 0;
      for (int i = 0; i < 3; i++) begin
         lvl[i] = 0;
         run[i] = 0;
      end
      for (int k = 0; k < 4; k++) due[k] = '0;
   endfunction

   function automatic void model_edge();
      logic [2:0] p;
      logic [2:0] pins;
      p    = due[0];
      pins = {push3, push2, push1};
      m_valid = 0;
      m_inv   = 0;
      if (m_state == 3) begin
         m_state = 0;
      end else if (p[0]) begin
         m_a     = int'(no);
         m_state = 1;
      end else if (p[1]) begin
         if (m_state != 0) begin
            m_b     = int'(no);
            m_state = 2;
         end
      end else if (p[2]) begin
         if (m_state == 2) begin
            if (no <= 4'd4) begin
               m_op    = int'(no[2:0]);
               m_state = 3;
               m_valid = 1;
            end else begin
               m_inv = 1;
            end
         end
      end
      due[0] = due[1];
      due[1] = due[2];
      due[2] = due[3];
      due[3] = '0;
      for (int i = 0; i < 3; i++) begin
         if (int'(pins[i]) != lvl[i]) begin
            run[i]++;
            if (run[i] == D) begin
               lvl[i] = 1 - lvl[i];
               run[i] = 0;
               if (lvl[i] == 1) due[3][i] = 1'b1;
            end
         end else begin
            run[i] = 0;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("a", int'(a), m_a);
      check("b", int'(b), m_b);
      check("opcode", int'(opcode), m_op);
      check("state", int'(state), m_state);
      check("valid", int'(valid), m_valid);
      check("invalid_op", int'(invalid_op), m_inv);
      if (valid) vcnt++;
      if (invalid_op) icnt++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_a", int'(a), 0);
      check("rst_b", int'(b), 0);
      check("rst_opcode", int'(opcode), 0);
      check("rst_state", int'(state), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_invalid", int'(invalid_op), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic press(input logic [3:0] val, input logic [2:0] pins, input int hold);
      no = val;
      {push3, push2, push1} = pins;
      repeat (hold) tick();
      {push3, push2, push1} = 3'b000;
      repeat (14) tick();
   endtask

   initial begin
      logic [9:0] bounce;
      rst = 1'b1;
      no  = 4'd0;
      {push3, push2, push1} = 3'b000;
      model_reset();
      #2;
      do_reset();

      // Clean entry with exact latency: pin first sampled at edge 0, field updates at edge 7.
      no = 4'd3; push1 = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 7) check("lat_a_early", int'(a), 0);
         if (c == 8) check("lat_a_edge7", int'(a), 3);
      end
      push1 = 1'b0;
      repeat (12) tick();
      no = 4'd5; push2 = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 7) check("lat_b_early", int'(b), 0);
         if (c == 8) check("lat_b_edge7", int'(b), 5);
      end
      push2 = 1'b0;
      repeat (12) tick();
      no = 4'd2; push3 = 1'b1;
      vcnt = 0;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 7) check("lat_op_early", int'(valid), 0);
         if (c == 8) begin
            check("lat_op_edge7", int'(opcode), 2);
            check("lat_valid", int'(valid), 1);
            check("lat_state_go", int'(state), 3);
         end
         if (c == 9) begin
            check("lat_valid_drop", int'(valid), 0);
            check("lat_state_back", int'(state), 0);
         end
      end
      push3 = 1'b0;
      repeat (12) tick();
      check("seq1_valid_count", vcnt, 1);

      do_reset();
      tbl[0]  = '{4'd9, 3'b001, 1,  0, 0, 0, 0, 0, 0};
      tbl[1]  = '{4'd9, 3'b001, 2,  0, 0, 0, 0, 0, 0};
      tbl[2]  = '{4'd9, 3'b001, 3,  0, 0, 0, 0, 0, 0};
      tbl[3]  = '{4'd9, 3'b001, 6,  9, 0, 0, 1, 0, 0};
      tbl[4]  = '{4'd6, 3'b011, 6,  6, 0, 0, 1, 0, 0};
      tbl[5]  = '{4'd5, 3'b100, 6,  6, 0, 0, 1, 0, 0};
      tbl[6]  = '{4'd5, 3'b010, 6,  6, 5, 0, 2, 0, 0};
      tbl[7]  = '{4'd7, 3'b100, 6,  6, 5, 0, 2, 0, 1};
      tbl[8]  = '{4'd4, 3'b100, 6,  6, 5, 4, 0, 1, 0};
      tbl[9]  = '{4'd1, 3'b010, 50, 6, 5, 4, 0, 0, 0};
      tbl[10] = '{4'd2, 3'b001, 50, 2, 5, 4, 1, 0, 0};
      for (int r = 0; r < 11; r++) begin
         vcnt = 0;
         icnt = 0;
         press(tbl[r].no, tbl[r].pins, tbl[r].hold);
         check($sformatf("tbl%0d_a", r), int'(a), tbl[r].ea);
         check($sformatf("tbl%0d_b", r), int'(b), tbl[r].eb);
         check($sformatf("tbl%0d_opcode", r), int'(opcode), tbl[r].eop);
         check($sformatf("tbl%0d_state", r), int'(state), tbl[r].est);
         check($sformatf("tbl%0d_valid_n", r), vcnt, tbl[r].env);
         check($sformatf("tbl%0d_invalid_n", r), icnt, tbl[r].eni);
      end

      // Long hold then bouncing release; switches change after the load so an extra press shows.
      no = 4'd11; push1 = 1'b1;
      repeat (10) tick();
      no = 4'd12;
      repeat (40) tick();
      bounce = 10'b0000100101;
      for (int i = 9; i >= 0; i--) begin
         push1 = bounce[i];
         tick();
      end
      push1 = 1'b0;
      repeat (15) tick();
      check("hold_a", int'(a), 11);
      check("hold_state", int'(state), 1);

      // Reset in S_OP with a press already accepted by the debouncer.
      press(4'd3, 3'b001, 6);
      press(4'd5, 3'b010, 6);
      check("pre_rst_state", int'(state), 2);
      check("pre_rst_a", int'(a), 3);
      check("pre_rst_b", int'(b), 5);
      no = 4'd9; push1 = 1'b1;
      repeat (6) tick();
      push1 = 1'b0;
      do_reset();
      vcnt = 0;
      repeat (15) tick();
      check("post_rst_a", int'(a), 0);
      check("post_rst_state", int'(state), 0);
      check("post_rst_valid_n", vcnt, 0);

      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(5) == 0) push1 = ~push1;
         if ($urandom_range(5) == 0) push2 = ~push2;
         if ($urandom_range(6) == 0) push3 = ~push3;
         if ($urandom_range(3) == 0) no = 4'($urandom_range(15));
         if ($urandom_range(799) == 0) do_reset();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
